rd_word_seq: RTL

Parametrised successor to the 2-bit FIFO read counter in the control block: it sequences `fifo_rd` strobes into B-byte word assemblies, issues one-hot byte-load enables to the datapath byte registers, and hands each completed word to the RAM writer over a valid/ack handshake with a running RAM address. It supports partial-word flush and a configurable full/wrap policy. It sits between the input FIFO read port and the RAM write port inside `ctrl_blk_2m`.

---
 rtl/rd_word_seq_pkg.sv | 16 +
 rtl/rd_mod_cnt.sv | 39 +++
 rtl/rd_word_seq.sv | 134 +++++++++++++
 3 files changed

// File: rtl/rd_word_seq_pkg.sv
// Shared types and helpers for the FIFO-read word sequencer.
package rd_word_seq_pkg;

  typedef enum logic [1:0] {
    FILL,
    LAST,
    VALID,
    FULL
  } rd_seq_state_t;

  // Index width for a modulo-n counter; never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rd_mod_cnt.sv
// Modulo-N up-counter with synchronous clear and a terminal-increment wrap pulse.
module rd_mod_cnt
  import rd_word_seq_pkg::*;
#(
  parameter int unsigned N = 4,
  localparam int unsigned W = idx_w(N)
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         wrap
);

  logic [W-1:0] cnt_q, cnt_d;

  assign wrap = inc && (cnt_q == W'(N - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr || wrap) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/rd_word_seq.sv
// Sequences FIFO reads into BYTES-wide words, drives byte-load enables and hands
// completed words to the RAM writer with a running address.
module rd_word_seq
  import rd_word_seq_pkg::*;
#(
  parameter int unsigned BYTES  = 4,
  parameter int unsigned ADDR_W = 11,
  parameter bit          WRAP   = 1'b0,
  localparam int unsigned CNT_W = idx_w(BYTES),
  localparam int unsigned WB_W  = $clog2(BYTES + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              fifo_empty,
  input  logic              flush,
  input  logic              word_ack,
  output logic              fifo_rd,
  output logic [BYTES-1:0]  byte_en,
  output logic              word_vld,
  output logic [WB_W-1:0]   word_bytes,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_full
);

  localparam logic [BYTES-1:0] BYTE0 = BYTES'(1);

  rd_seq_state_t     state_q, state_d;
  logic [BYTES-1:0]  byte_en_q, byte_en_d;
  logic              word_vld_q, word_vld_d;
  logic [WB_W-1:0]   word_bytes_q, word_bytes_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic              ram_full_q, ram_full_d;

  logic [CNT_W-1:0]  cnt;
  logic              cnt_wrap;
  logic              flush_take;

  assign fifo_rd    = (state_q == FILL) && !fifo_empty;
  // A read in the same cycle always wins over flush; an empty partial word is not emitted.
  assign flush_take = (state_q == FILL) && flush && !fifo_rd && (cnt != '0);

  rd_mod_cnt #(
    .N (BYTES)
  ) u_byte_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (clear || flush_take),
    .inc     (fifo_rd),
    .cnt     (cnt),
    .wrap    (cnt_wrap)
  );

  always_comb begin
    state_d      = state_q;
    byte_en_d    = '0;
    word_vld_d   = 1'b0;
    word_bytes_d = word_bytes_q;
    ram_addr_d   = ram_addr_q;
    ram_full_d   = ram_full_q;

    case (state_q)
      FILL: begin
        if (fifo_rd) begin
          byte_en_d = BYTE0 << cnt;
          if (cnt_wrap) begin
            state_d      = LAST;
            word_bytes_d = WB_W'(BYTES);
          end
        end else if (flush_take) begin
          state_d      = LAST;
          word_bytes_d = WB_W'(cnt);
        end
      end
      LAST: begin
        state_d    = VALID;
        word_vld_d = 1'b1;
      end
      VALID: begin
        word_vld_d = 1'b1;
        if (word_ack) begin
          word_vld_d = 1'b0;
          if ((WRAP == 1'b0) && (&ram_addr_q)) begin
            state_d    = FULL;
            ram_full_d = 1'b1;
          end else begin
            ram_addr_d = ram_addr_q + ADDR_W'(1);
            state_d    = FILL;
          end
        end
      end
      FULL: begin
        state_d = FULL;
      end
      default: begin
        state_d = FILL;
      end
    endcase

    if (clear) begin
      state_d      = FILL;
      byte_en_d    = '0;
      word_vld_d   = 1'b0;
      word_bytes_d = '0;
      ram_addr_d   = '0;
      ram_full_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= FILL;
      byte_en_q    <= '0;
      word_vld_q   <= 1'b0;
      word_bytes_q <= '0;
      ram_addr_q   <= '0;
      ram_full_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_en_q    <= byte_en_d;
      word_vld_q   <= word_vld_d;
      word_bytes_q <= word_bytes_d;
      ram_addr_q   <= ram_addr_d;
      ram_full_q   <= ram_full_d;
    end
  end

  assign byte_en    = byte_en_q;
  assign word_vld   = word_vld_q;
  assign word_bytes = word_bytes_q;
  assign ram_addr   = ram_addr_q;
  assign ram_full   = ram_full_q;

endmodule
